// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
`default_nettype none
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: MSB-first shift register plus byte position counter.
`default_nettype none
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Word as it will look once the byte on byte_in is shifted in.
  assign word          = {shift_q[WORD_W-BYTE_W-1:0], byte_in};
  assign word_complete = shift_en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
// Loads a host byte stream into instruction memory, holding the core stalled
// while the load is in progress.
`default_nettype none
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic [BYTE_W-1:0] ByteIn,
  input  logic              ByteValid,
  input  logic              ByteLast,
  output logic              ByteReady,
  output logic              ImWE,
  output logic [AW-1:0]     ImAddr,
  output logic [WORD_W-1:0] ImData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error,
  output logic [AW:0]       WordCount
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              imwe_q, imwe_d;
  logic [AW-1:0]     imaddr_q, imaddr_d;
  logic [WORD_W-1:0] imdata_q, imdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              last_q, last_d;
  logic [AW:0]       idx_q, idx_d;

  logic              hs;
  logic              pk_clr;
  logic [WORD_W-1:0] pk_word;
  logic              pk_complete;

  // ready_q mirrors state_q==LOAD, so this is the handshake.
  assign hs = ByteValid && ready_q;

  byte_packer u_packer (
    .clock         (clock),
    .reset_n       (reset_n),
    .clr           (pk_clr),
    .shift_en      (hs),
    .byte_in       (ByteIn),
    .word          (pk_word),
    .word_complete (pk_complete)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    error_d  = error_q;
    imwe_d   = 1'b0;
    imaddr_d = imaddr_q;
    imdata_d = imdata_q;
    pk_clr   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = LOAD;
          idx_d   = '0;
          error_d = 1'b0;
          last_d  = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      LOAD: begin
        if (hs) begin
          if (pk_complete) begin
            // Index never wraps: a full word beyond DEPTH-1 ends the load.
            if (idx_q == (AW+1)'(DEPTH)) begin
              state_d = DONE;
              error_d = 1'b1;
            end else begin
              state_d  = WRITE;
              imwe_d   = 1'b1;
              imaddr_d = idx_q[AW-1:0];
              imdata_d = pk_word;
              last_d   = ByteLast;
            end
          end else if (ByteLast) begin
            state_d = DONE;
            error_d = 1'b1;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = last_q ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    hold_d  = (state_d == LOAD) || (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      imwe_q   <= 1'b0;
      imaddr_q <= '0;
      imdata_q <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      imwe_q   <= imwe_d;
      imaddr_q <= imaddr_d;
      imdata_q <= imdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
    end
  end

  assign ByteReady = ready_q;
  assign ImWE      = imwe_q;
  assign ImAddr    = imaddr_q;
  assign ImData    = imdata_q;
  assign CpuHold   = hold_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign WordCount = idx_q;

endmodule
`default_nettype wire
